ro_freq_meter: RTL and testbench



---
 rtl/ro_meas_pkg.sv | 30 +++
 rtl/ro_sync_edge.sv | 45 ++++
 rtl/ro_freq_meter.sv | 185 ++++++++++++++++++
 tb/tb_ro_freq_meter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_meas_pkg.sv
// ---------------------------------------------------------------------------
// ro_meas_pkg
// Shared definitions for the ring-oscillator frequency meter.
//   - DEF_CNT_W / DEF_WIN_W : default edge-counter and gate-window widths
//   - ro_state_e            : measurement FSM state encoding
//   - ro_state_active()     : true in the states that keep the RO enabled
// ---------------------------------------------------------------------------
package ro_meas_pkg;

   // Default widths used when the top is instantiated without overrides.
   localparam int DEF_CNT_W = 16;
   localparam int DEF_WIN_W = 12;

   // Measurement sequence. The numeric values are fixed because downstream
   // debug tooling decodes the raw 2-bit state.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_GATE   = 2'd2,
      ST_DONE   = 2'd3
   } ro_state_e;

   // The RO must be running while it settles and while its edges are counted.
   // DONE deliberately drops the enable so the oscillator stops as soon as
   // the count is frozen.
   function automatic logic ro_state_active(input logic [1:0] st);
      return (st == ST_SETTLE) || (st == ST_GATE);
   endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// ---------------------------------------------------------------------------
// ro_sync_edge
// Brings the asynchronous RO tap into the ro_clk domain and flags each rising
// edge for exactly one ro_clk cycle.
// Ports:
//   ro_clk    in   measurement clock
//   ro_rst_n  in   asynchronous active-low reset
//   meas      in   asynchronous RO signal (must toggle below f(ro_clk)/2)
//   rise_o    out  one-cycle pulse per synchronised rising edge
// Parameters:
//   SYNC_STAGES  number of synchroniser flops, must be 2 or more
// ---------------------------------------------------------------------------
module ro_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic ro_clk,
   input  logic ro_rst_n,
   input  logic meas,
   output logic rise_o
);

   // Metastability chain. The attributes keep the flops together and stop
   // synthesis from merging or retiming them.
   (* async_reg = "true", keep = "true" *) logic [SYNC_STAGES-1:0] sync_q;

   // Previous value of the synchronised signal, used only for edge detection.
   logic prev_q;

   // Shift the raw RO signal through the synchroniser and keep one extra
   // delayed copy. This runs in every FSM state so the chain is already
   // settled by the time the gate opens.
   always_ff @(posedge ro_clk or negedge ro_rst_n) begin
      if (!ro_rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], meas};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // A rising edge is "now high, previously low".
   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_meter.sv
// ---------------------------------------------------------------------------
// ro_freq_meter
// Ring-oscillator frequency meter. On start it enables the RO, waits a fixed
// settle interval, counts synchronised rising edges of the RO tap over a
// programmable gate window of ro_clk cycles, then publishes the held count
// with a one-cycle done pulse.
// Ports:
//   ro_clk      in   measurement clock
//   ro_rst_n    in   asynchronous active-low reset
//   ro_meas_i   in   asynchronous RO signal being measured
//   ro_start    in   start request, only honoured in IDLE
//   ro_abort    in   abort request, only honoured in SETTLE and GATE
//   ro_win_len  in   gate length in ro_clk cycles (0 = empty window)
//   ro_en_o     out  RO enable, high during SETTLE and GATE
//   ro_busy     out  high whenever a measurement is in progress
//   ro_done     out  one-cycle pulse when a result is published
//   ro_count_q  out  last published edge count
//   ro_ovf      out  last published count saturated
// Parameters:
//   CNT_W        edge counter / result width
//   WIN_W        gate window length width
//   SYNC_STAGES  input synchroniser depth (>= 2)
//   SETTLE_CYC   cycles between RO enable and gate open (>= SYNC_STAGES+1)
// ---------------------------------------------------------------------------
module ro_freq_meter
   import ro_meas_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int WIN_W       = DEF_WIN_W,
   parameter int SYNC_STAGES = 2,
   parameter int SETTLE_CYC  = 8
) (
   input  logic             ro_clk,
   input  logic             ro_rst_n,
   input  logic             ro_meas_i,
   input  logic             ro_start,
   input  logic             ro_abort,
   input  logic [WIN_W-1:0] ro_win_len,
   output logic             ro_en_o,
   output logic             ro_busy,
   output logic             ro_done,
   output logic [CNT_W-1:0] ro_count_q,
   output logic             ro_ovf
);

   // The same timer paces both SETTLE and GATE, so it has to be wide enough
   // for whichever of the two intervals is longer.
   localparam int SET_W = $clog2(SETTLE_CYC + 1);
   localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;

   // Legacy-style state constants tied to the shared encoding.
   localparam logic [1:0] IDLE   = ST_IDLE;
   localparam logic [1:0] SETTLE = ST_SETTLE;
   localparam logic [1:0] GATE   = ST_GATE;
   localparam logic [1:0] DONE   = ST_DONE;

   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [TMR_W-1:0] tmr_q;
   logic [WIN_W-1:0] win_r;
   logic [CNT_W-1:0] edge_cnt;
   logic             ovf_r;
   logic             rise;
   logic             settle_last;
   logic             gate_last;
   logic             start_ok;

   // Edge detection on the asynchronous RO tap.
   ro_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .ro_clk   (ro_clk),
      .ro_rst_n (ro_rst_n),
      .meas     (ro_meas_i),
      .rise_o   (rise)
   );

   // Interval end markers. gate_last is only consulted in GATE, where win_r
   // is known to be non-zero, so the subtraction never wraps in use.
   assign settle_last = (tmr_q == SETTLE_LAST);
   assign gate_last   = (tmr_q == (TMR_W'(win_r) - TMR_W'(1)));
   assign start_ok    = (state_q == IDLE) && ro_start;

   // Next-state logic. Abort is checked before the interval-end transitions
   // so an abort on the final GATE cycle still suppresses the result. A
   // start in IDLE wins over a simultaneous abort simply because abort is
   // not looked at in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (ro_start) begin
               state_d = SETTLE;
            end
         end
         SETTLE: begin
            if (ro_abort) begin
               state_d = IDLE;
            end else if (settle_last) begin
               state_d = (win_r != '0) ? GATE : DONE;
            end
         end
         GATE: begin
            if (ro_abort) begin
               state_d = IDLE;
            end else if (gate_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register. Reset is asynchronous so the RO enable falls the moment
   // reset is asserted, even in the middle of a gate window.
   always_ff @(posedge ro_clk or negedge ro_rst_n) begin
      if (!ro_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Interval timer. It restarts from zero on every state change, so each
   // state sees a fresh count starting at 0 on its first cycle; SETTLE then
   // lasts SETTLE_CYC cycles and GATE lasts win_r cycles. It is held at zero
   // while idle so a start always begins from a clean value.
   always_ff @(posedge ro_clk or negedge ro_rst_n) begin
      if (!ro_rst_n) begin
         tmr_q <= '0;
      end else if ((state_q == IDLE) || (state_d != state_q)) begin
         tmr_q <= '0;
      end else begin
         tmr_q <= tmr_q + TMR_W'(1);
      end
   end

   // Measurement datapath. The window length is captured at start so later
   // changes on ro_win_len cannot disturb a running measurement. Edges are
   // only counted in GATE; once the counter is full, any further edge marks
   // the result as saturated instead of wrapping.
   always_ff @(posedge ro_clk or negedge ro_rst_n) begin
      if (!ro_rst_n) begin
         win_r    <= '0;
         edge_cnt <= '0;
         ovf_r    <= 1'b0;
      end else if (start_ok) begin
         win_r    <= ro_win_len;
         edge_cnt <= '0;
         ovf_r    <= 1'b0;
      end else if ((state_q == GATE) && rise) begin
         if (&edge_cnt) begin
            ovf_r <= 1'b1;
         end else begin
            edge_cnt <= edge_cnt + CNT_W'(1);
         end
      end
   end

   // Published result. Updated only on the DONE cycle, so an aborted run
   // leaves the previous result untouched and the value holds between runs.
   always_ff @(posedge ro_clk or negedge ro_rst_n) begin
      if (!ro_rst_n) begin
         ro_count_q <= '0;
         ro_ovf     <= 1'b0;
      end else if (state_q == DONE) begin
         ro_count_q <= edge_cnt;
         ro_ovf     <= ovf_r;
      end
   end

   // Status outputs decode straight from the state register so they follow
   // an asynchronous reset immediately.
   assign ro_en_o = ro_state_active(state_q);
   assign ro_busy = (state_q != IDLE);
   assign ro_done = (state_q == DONE);

endmodule

// File: tb/tb_ro_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_ro_freq_meter
// Self-checking bench for ro_freq_meter. Two instances share all inputs: a
// default-width one and one with a 4-bit counter for saturation behaviour.
// A table of windows / RO periods with expected latency, enable time and
// count range drives the main loop; hand-written sequences cover restart
// during GATE, abort, start+abort together, and asynchronous reset mid-GATE.
// ---------------------------------------------------------------------------
module tb_ro_freq_meter;

   localparam int TB_WIN_W   = 12;
   localparam int TB_CNT_W   = 16;
   localparam int SMALL_W    = 4;
   localparam int SETTLE_CYC = 8;

   // One measurement record: stimulus plus everything expected from it.
   typedef struct {
      int win;
      int div;
      int lat;
      int en;
      int lo;
      int hi;
      int ovf;
      int bSat;
   } vec_t;

   logic                ro_clk;
   logic                ro_rst_n;
   logic                ro_meas_i;
   logic                ro_start;
   logic                ro_abort;
   logic [TB_WIN_W-1:0] ro_win_len;

   logic                ro_en_o;
   logic                ro_busy;
   logic                ro_done;
   logic [TB_CNT_W-1:0] ro_count_q;
   logic                ro_ovf;

   logic                en_b;
   logic                busy_b;
   logic                done_b;
   logic [SMALL_W-1:0]  count_b;
   logic                ovf_b;

   int   tests;
   int   fails;
   int   meas_div;
   int   div_cnt;
   int   lastLo;
   int   lastHi;
   int   lastOvf;
   vec_t sbQ[$];
   vec_t vecs[8];

   ro_freq_meter #(
      .CNT_W       (TB_CNT_W),
      .WIN_W       (TB_WIN_W),
      .SYNC_STAGES (2),
      .SETTLE_CYC  (SETTLE_CYC)
   ) dut (
      .ro_clk     (ro_clk),
      .ro_rst_n   (ro_rst_n),
      .ro_meas_i  (ro_meas_i),
      .ro_start   (ro_start),
      .ro_abort   (ro_abort),
      .ro_win_len (ro_win_len),
      .ro_en_o    (ro_en_o),
      .ro_busy    (ro_busy),
      .ro_done    (ro_done),
      .ro_count_q (ro_count_q),
      .ro_ovf     (ro_ovf)
   );

   ro_freq_meter #(
      .CNT_W       (SMALL_W),
      .WIN_W       (TB_WIN_W),
      .SYNC_STAGES (2),
      .SETTLE_CYC  (SETTLE_CYC)
   ) dut_small (
      .ro_clk     (ro_clk),
      .ro_rst_n   (ro_rst_n),
      .ro_meas_i  (ro_meas_i),
      .ro_start   (ro_start),
      .ro_abort   (ro_abort),
      .ro_win_len (ro_win_len),
      .ro_en_o    (en_b),
      .ro_busy    (busy_b),
      .ro_done    (done_b),
      .ro_count_q (count_b),
      .ro_ovf     (ovf_b)
   );

   // 10 ns measurement clock.
   initial begin
      ro_clk = 1'b0;
      forever #5 ro_clk = ~ro_clk;
   end

   // RO stand-in: a square wave with a period of meas_div ro_clk cycles,
   // changing on the falling edge. meas_div = 0 holds the signal low.
   initial begin
      ro_meas_i = 1'b0;
      div_cnt   = 0;
      forever begin
         @(negedge ro_clk);
         if (meas_div > 0) begin
            div_cnt   = (div_cnt + 1) % meas_div;
            ro_meas_i = (div_cnt < (meas_div / 2)) || (meas_div == 1);
         end else begin
            ro_meas_i = 1'b0;
         end
      end
   end

   // Hard stop in case the DUT never lets a sequence finish.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: actual value must lie in [lo, hi].
   task automatic checkOutput(input string name, input int act, input int lo, input int hi);
      tests++;
      if ((act < lo) || (act > hi)) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Every output of both instances must read zero.
   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_en"},      ro_en_o,    0, 0);
      checkOutput({tag, "_busy"},    ro_busy,    0, 0);
      checkOutput({tag, "_done"},    ro_done,    0, 0);
      checkOutput({tag, "_count"},   ro_count_q, 0, 0);
      checkOutput({tag, "_ovf"},     ro_ovf,     0, 0);
      checkOutput({tag, "_en_b"},    en_b,       0, 0);
      checkOutput({tag, "_busy_b"},  busy_b,     0, 0);
      checkOutput({tag, "_done_b"},  done_b,     0, 0);
      checkOutput({tag, "_count_b"}, count_b,    0, 0);
      checkOutput({tag, "_ovf_b"},   ovf_b,      0, 0);
   endtask

   // Pop the scoreboard entry for a published result and compare it.
   task automatic checkResult(input int doneAt, input int enCnt);
      vec_t e;
      checkOutput("sb_depth", sbQ.size(), 1, 1);
      if (sbQ.size() > 0) begin
         e = sbQ.pop_front();
         checkOutput("latency",    doneAt,     e.lat, e.lat);
         checkOutput("en_cycles",  enCnt,      e.en,  e.en);
         checkOutput("count",      ro_count_q, e.lo,  e.hi);
         checkOutput("ovf",        ro_ovf,     e.ovf, e.ovf);
         if (e.bSat != 0) begin
            checkOutput("count_small", count_b, 15, 15);
            checkOutput("ovf_small",   ovf_b,   1,  1);
         end else begin
            checkOutput("count_small", count_b, e.lo, e.hi);
            checkOutput("ovf_small",   ovf_b,   0,  0);
         end
         lastLo  = e.lo;
         lastHi  = e.hi;
         lastOvf = e.ovf;
      end
   endtask

   // Run one measurement. Cycle k counts ro_clk rising edges after the one
   // that samples ro_start; outputs are looked at on the following falling
   // edge. Optional: re-pulse start at restartAt with a new length, abort at
   // abortAt, or hold abort together with the initial start.
   task automatic applyStimulus(input vec_t v, input int restartAt, input int restartWin,
                                input int abortAt, input bit abortWithStart);
      int doneAt;
      int doneCnt;
      int doneCntB;
      int enCnt;
      int budget;
      int expDone;
      expDone    = (abortAt == 0) ? 1 : 0;
      meas_div   = v.div;
      ro_win_len = TB_WIN_W'(v.win);
      ro_start   = 1'b1;
      ro_abort   = abortWithStart;
      if (expDone != 0) begin
         sbQ.push_back(v);
      end
      doneAt   = -1;
      doneCnt  = 0;
      doneCntB = 0;
      enCnt    = 0;
      budget   = SETTLE_CYC + v.win + 20;
      for (int k = 1; k <= budget; k++) begin
         @(negedge ro_clk);
         ro_start = 1'b0;
         ro_abort = 1'b0;
         if (k == restartAt) begin
            ro_start   = 1'b1;
            ro_win_len = TB_WIN_W'(restartWin);
         end
         if (k == abortAt) begin
            ro_abort = 1'b1;
         end
         if (ro_en_o) enCnt++;
         if (ro_done) begin
            doneCnt++;
            if (doneAt < 0) doneAt = k;
         end
         if (done_b) doneCntB++;
         if ((abortAt > 0) && (k == abortAt + 1)) begin
            checkOutput("abort_busy", ro_busy, 0, 0);
            checkOutput("abort_en",   ro_en_o, 0, 0);
         end
         if ((doneAt >= 0) && (k == doneAt + 1)) begin
            checkResult(doneAt, enCnt);
         end
      end
      checkOutput("done_pulses",   doneCnt,  expDone, expDone);
      checkOutput("done_pulses_b", doneCntB, expDone, expDone);
      checkOutput("sb_drain",      sbQ.size(), 0, 0);
      sbQ.delete();
      if (expDone == 0) begin
         checkOutput("abort_hold_count", ro_count_q, lastLo,  lastHi);
         checkOutput("abort_hold_ovf",   ro_ovf,     lastOvf, lastOvf);
      end
   endtask

   initial begin
      vec_t v;
      tests      = 0;
      fails      = 0;
      meas_div   = 0;
      lastLo     = 0;
      lastHi     = 0;
      lastOvf    = 0;
      ro_start   = 1'b0;
      ro_abort   = 1'b0;
      ro_win_len = '0;
      ro_rst_n   = 1'b0;

      // win, div, done latency, enable cycles, count lo..hi, ovf, 4-bit saturates
      vecs[0] = '{100, 4, 109, 108, 24, 26, 0, 1};
      vecs[1] = '{0,   4, 9,   8,   0,  0,  0, 0};
      vecs[2] = '{64,  2, 73,  72,  31, 33, 0, 1};
      vecs[3] = '{40,  4, 49,  48,  9,  11, 0, 0};
      vecs[4] = '{1,   0, 10,  9,   0,  0,  0, 0};
      vecs[5] = '{60,  3, 69,  68,  19, 21, 0, 1};
      vecs[6] = '{200, 8, 209, 208, 24, 26, 0, 1};
      vecs[7] = '{7,   2, 16,  15,  2,  5,  0, 0};

      repeat (3) @(negedge ro_clk);
      checkAllZero("reset");
      ro_rst_n = 1'b1;
      repeat (2) @(negedge ro_clk);
      checkAllZero("idle");

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i], 0, 0, 0, 1'b0);
         repeat (3) @(negedge ro_clk);
      end

      // Restart during GATE with a shorter length must be ignored.
      v = '{100, 4, 109, 108, 24, 26, 0, 1};
      applyStimulus(v, 20, 5, 0, 1'b0);
      repeat (3) @(negedge ro_clk);

      // Abort mid-GATE at a faster RO: nothing published, previous result kept.
      v = '{100, 2, 109, 108, 49, 51, 0, 1};
      applyStimulus(v, 0, 0, 30, 1'b0);
      repeat (3) @(negedge ro_clk);

      // Start and abort together in IDLE: start wins.
      v = '{20, 4, 29, 28, 4, 6, 0, 0};
      applyStimulus(v, 0, 0, 0, 1'b1);
      repeat (3) @(negedge ro_clk);

      // Asynchronous reset in the middle of GATE.
      meas_div   = 4;
      ro_win_len = TB_WIN_W'(100);
      ro_start   = 1'b1;
      @(negedge ro_clk);
      ro_start = 1'b0;
      repeat (30) @(negedge ro_clk);
      checkOutput("pre_reset_en",   ro_en_o, 1, 1);
      checkOutput("pre_reset_busy", ro_busy, 1, 1);
      #2;
      ro_rst_n = 1'b0;
      #1;
      checkAllZero("async_reset");
      @(negedge ro_clk);
      ro_rst_n = 1'b1;
      lastLo   = 0;
      lastHi   = 0;
      lastOvf  = 0;
      @(negedge ro_clk);
      checkAllZero("post_reset");
      v = '{100, 4, 109, 108, 24, 26, 0, 1};
      applyStimulus(v, 0, 0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
